mux8to1_rr_collector: RTL and testbench
=======================================

MUX8TO1_RR_COLLECTOR -- requirements
Module: mux8to1_rr_collector

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, the payload width per channel.
REQ-002 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req, input, 8 bits: per-channel request; bit i means channel i presents valid data.
REQ-006 Port data_in, input, 8*DATA_W bits: channel i payload at bits [i*DATA_W +: DATA_W].
REQ-007 Port grant, output, 8 bits: one-hot, single-cycle pulse; channel i payload was captured this cycle.
REQ-008 Port out_valid, output, 1 bit: out_data and out_sel hold a transfer.
REQ-009 Port out_ready, input, 1 bit: the downstream accepts the transfer this cycle.
REQ-010 Port out_data, output, DATA_W bits: the captured payload.
REQ-011 Port out_sel, output, 3 bits: source channel index, encoded as {s2,s1,s0} to match the 1-to-8 demux select ordering.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 The FSM SHALL have two states.
- IDLE: out_valid=0.
- FULL: out_valid=1.
REQ-014 The load condition SHALL be (state==IDLE or (state==FULL and out_ready==1)) and req!=0.
REQ-015 Selection SHALL be round-robin over the request vector.
- Scan channels ptr, ptr+1, ... modulo 8.
- The first channel with req=1 wins.
REQ-016 On load, at the clock edge:
- out_data is set to the winner's payload.
- out_sel is set to the winner's index.
- grant is set to the winner's one-hot bit for exactly one cycle.
- ptr is set to (winner+1) mod 8.
- state goes to FULL.
REQ-017 Wrap-around: winner 7 SHALL set ptr to 0.
REQ-018 When out_ready=1 in FULL and req==0, state SHALL go to IDLE and out_valid SHALL fall at the next edge.
REQ-019 In FULL with out_ready=0:
- out_data, out_sel and out_valid SHALL remain stable.
- No grant SHALL be issued.
- ptr SHALL be unchanged.
REQ-020 Back-to-back transfers: with out_ready held high and requests pending, one transfer SHALL be loaded every cycle and out_valid SHALL stay high.
REQ-021 Latency: from req rising in IDLE, out_valid and grant SHALL assert at the first rising edge where req is sampled high (1 cycle).
REQ-022 Requester rules:
- A requester SHALL hold req and data until it sees grant.
- A req still high in the cycle after its grant SHALL be treated as a new request.
REQ-023 Starvation bound: any continuously asserted req SHALL be granted within 8 loads.
REQ-024 grant SHALL be all-zero whenever no load occurs; at most one grant bit SHALL be high per cycle.
REQ-025 out_data and out_sel SHALL keep their last values when returning to IDLE; they are don't-care when out_valid=0.
REQ-026 Payload bits of unselected channels SHALL never affect out_data.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set:
- state=IDLE, ptr=0
- out_valid=0, out_data=0, out_sel=0, grant=0
REQ-028 rst SHALL take priority over load and over out_ready; asserting it in FULL SHALL discard the held transfer.
REQ-029 No grant SHALL be issued in any cycle in which rst=1.
REQ-030 The first load after reset release SHALL scan starting from channel 0.

Verification
REQ-031 Reset check:
- Stimulus: rst=1 for 2 cycles with req=8'hFF.
- Response: grant=0, out_valid=0, out_sel=0, out_data=0 throughout.
- After release: first grant=8'h01, out_sel=0.
REQ-032 Single channel:
- Stimulus: req=8'h20 with ch5 data=8'hA5 in IDLE, out_ready=1.
- Response: next edge gives grant=8'h20, out_valid=1, out_sel=5, out_data=8'hA5.
- req dropped after grant: out_valid=0 one cycle later.
REQ-033 Round-robin with wrap:
- Stimulus: req=8'hFF held, out_ready=1 from reset.
- Response: out_sel sequence 0,1,...,7,0,1; out_valid continuously 1; one grant bit per cycle.
REQ-034 Backpressure:
- Stimulus: req=8'h81, out_ready=0 for 4 cycles, then out_ready=1.
- Response: out_sel=0 and out_data stable for 4 cycles, no grant during the stall.
- Then out_sel=7 with grant=8'h80 at the edge after out_ready rises.
REQ-035 Reset mid-transfer:
- Stimulus: FULL with out_sel=3, out_ready=0; assert rst for 1 cycle with req=8'h08 still high.
- Response: out_valid=0 and grant=0 during reset.
- After release: ch3 is regranted with ptr starting at 0.
REQ-036 Payload isolation: toggle data on all unrequested channels every cycle while ch2 is granted; out_data SHALL always equal ch2's captured value.

Source files
------------

// File: rtl/mux8to1_rr_collector.sv
// mux8to1_rr_collector
// Collects one payload at a time from eight requesting channels, picking the
// winner round-robin, and holds it in a single output register slot until the
// downstream accepts it.
//
// Handshake: a transfer is presented while out_valid=1 and is consumed on a
// rising edge where out_valid=1 and out_ready=1; out_data/out_sel stay stable
// while out_valid=1 and out_ready=0. On the upstream side, grant[i] pulses for
// one cycle to tell channel i that its payload was captured at that edge.
module mux8to1_rr_collector #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] data_in,
  output logic [7:0]          grant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [2:0]          out_sel
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        grant_q, grant_d;

  logic              found;
  logic [2:0]        win_idx;
  logic [2:0]        scan_idx;
  logic [DATA_W-1:0] win_data;
  logic              load;

  // Round-robin scan: first requesting channel at or after ptr (mod 8) wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = 3'd0;
    scan_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!found && req[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Only the winner's slice is routed, so other channels cannot leak through.
  assign win_data = data_in[win_idx*DATA_W +: DATA_W];

  // The slot can take a new payload when empty or when it is draining now.
  assign load = ((state_q == ST_IDLE) || out_ready) && found;

  // Next-state, pointer, payload and grant computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    grant_d = 8'd0;
    if (load) begin
      state_d = ST_FULL;
      ptr_d   = win_idx + 3'd1;
      data_d  = win_data;
      sel_d   = win_idx;
      grant_d = 8'd1 << win_idx;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  // State registers; reset wins over load and over out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      data_q  <= '0;
      sel_q   <= 3'd0;
      grant_q <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mux8to1_rr_collector.sv
// Directed bench for mux8to1_rr_collector.
module tb_mux8to1_rr_collector;

  localparam int DATA_W = 8;

  logic                clk;
  logic                rst;
  logic [7:0]          req;
  logic [8*DATA_W-1:0] data_in;
  logic [7:0]          grant;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [2:0]          out_sel;

  int pass_cnt;
  int total_cnt;

  mux8to1_rr_collector #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] v);
    data_in[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_grant, input logic e_valid,
                         input logic [2:0] e_sel, input logic [7:0] e_data);
    chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".sel"}, 32'(out_sel), 32'(e_sel));
    chk({tag, ".data"}, 32'(out_data), 32'(e_data));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    data_in   = '0;
    for (int i = 0; i < 8; i++) set_ch(i, 8'(8'h30 + i));

    // Reset with every channel requesting
    step();
    chk_all("rst0", 8'h00, 1'b0, 3'd0, 8'h00);
    step();
    chk_all("rst1", 8'h00, 1'b0, 3'd0, 8'h00);
    rst = 1'b0;

    // First load after release scans from channel 0, then round-robin with wrap
    step();
    chk_all("rr0", 8'h01, 1'b1, 3'd0, 8'h30);
    for (int k = 1; k < 10; k++) begin
      step();
      chk_all($sformatf("rr%0d", k), 8'(8'd1 << (k % 8)), 1'b1, 3'(k % 8), 8'(8'h30 + (k % 8)));
      chk($sformatf("rr%0d.onehot", k), 32'($onehot(grant)), 32'd1);
    end

    // Drain to IDLE: out_sel/out_data keep last values (ch1), ptr now 2
    req = 8'h00;
    step();
    chk_all("drain", 8'h00, 1'b0, 3'd1, 8'h31);

    // Single channel from IDLE
    set_ch(5, 8'hA5);
    req = 8'h20;
    step();
    chk_all("single", 8'h20, 1'b1, 3'd5, 8'hA5);
    req = 8'h00;
    step();
    chk_all("single_drop", 8'h00, 1'b0, 3'd5, 8'hA5);

    // Backpressure, starting from a fresh reset so ptr=0
    rst = 1'b1;
    step();
    chk_all("bp_rst", 8'h00, 1'b0, 3'd0, 8'h00);
    rst       = 1'b0;
    set_ch(0, 8'h5A);
    set_ch(7, 8'hE7);
    req       = 8'h81;
    out_ready = 1'b0;
    step();
    chk_all("bp_load", 8'h01, 1'b1, 3'd0, 8'h5A);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all($sformatf("bp_stall%0d", k), 8'h00, 1'b1, 3'd0, 8'h5A);
    end
    out_ready = 1'b1;
    step();
    chk_all("bp_release", 8'h80, 1'b1, 3'd7, 8'hE7);

    // Reset mid-transfer: hold ch3 in FULL, then reset
    set_ch(3, 8'h33);
    req = 8'h08;
    step();
    chk_all("mid_load", 8'h08, 1'b1, 3'd3, 8'h33);
    out_ready = 1'b0;
    step();
    chk_all("mid_stall", 8'h00, 1'b1, 3'd3, 8'h33);
    rst = 1'b1;
    step();
    chk_all("mid_rst", 8'h00, 1'b0, 3'd0, 8'h00);
    rst = 1'b0;
    step();
    chk_all("mid_regrant", 8'h08, 1'b1, 3'd3, 8'h33);

    // Payload isolation: ch2 held, all other channels toggle every cycle
    set_ch(2, 8'hC2);
    req       = 8'h04;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) if (i != 2) set_ch(i, 8'($urandom_range(0, 255)));
      step();
      chk_all($sformatf("iso%0d", k), 8'h04, 1'b1, 3'd2, 8'hC2);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) set_ch(i, 8'($urandom_range(0, 255)));
      step();
      chk_all($sformatf("iso_stall%0d", k), 8'h00, 1'b1, 3'd2, 8'hC2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
